// File: rtl/pause_controller.sv
// Pause/resume controller: toggles on debounced button presses, gates the game tick,
// runs a visible countdown before resuming and latches game-over until reset.
module pause_controller #(
    parameter int unsigned TICK_DIV    = 2500000,
    parameter int unsigned SEC_DIV     = 100000000,
    parameter int unsigned RESUME_SECS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_state,
    input  logic       game_over,
    output logic       game_tick,
    output logic       paused,
    output logic       resuming,
    output logic       over,
    output logic [3:0] countdown
);

    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned SecW  = $clog2(SEC_DIV);

    localparam logic [TickW-1:0] TickMax   = TickW'(TICK_DIV - 1);
    localparam logic [SecW-1:0]  SecMax    = SecW'(SEC_DIV - 1);
    localparam logic [3:0]       ResumeVal = 4'(RESUME_SECS);

    typedef enum logic [1:0] {
        StRunning,
        StPaused,
        StResuming,
        StOver
    } state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SecW-1:0]  sec_cnt_q, sec_cnt_d;
    logic [3:0]       countdown_q, countdown_d;
    logic             pause_q;
    logic             game_tick_q, game_tick_d;
    logic             paused_q, paused_d;
    logic             resuming_q, resuming_d;
    logic             over_q, over_d;

    logic press;
    logic tick_term;
    logic sec_term;

    assign press     = pause_state & ~pause_q;
    assign tick_term = (tick_cnt_q == TickMax);
    assign sec_term  = (sec_cnt_q == SecMax);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        sec_cnt_d   = sec_cnt_q;
        countdown_d = countdown_q;
        game_tick_d = 1'b0;

        if (game_over) begin
            state_d     = StOver;
            countdown_d = 4'd0;
        end else begin
            case (state_q)
                StRunning: begin
                    // A press freezes tick_cnt so the tick phase survives the pause.
                    if (press) begin
                        state_d = StPaused;
                    end else begin
                        game_tick_d = tick_term;
                        tick_cnt_d  = tick_term ? '0 : tick_cnt_q + 1'b1;
                    end
                end
                StPaused: begin
                    sec_cnt_d = '0;
                    if (press) begin
                        if (RESUME_SECS == 0) begin
                            state_d = StRunning;
                        end else begin
                            state_d     = StResuming;
                            countdown_d = ResumeVal;
                        end
                    end
                end
                StResuming: begin
                    if (press) begin
                        state_d     = StPaused;
                        countdown_d = 4'd0;
                        sec_cnt_d   = '0;
                    end else if (sec_term) begin
                        sec_cnt_d = '0;
                        if (countdown_q == 4'd1) begin
                            state_d     = StRunning;
                            countdown_d = 4'd0;
                        end else begin
                            countdown_d = countdown_q - 4'd1;
                        end
                    end else begin
                        sec_cnt_d = sec_cnt_q + 1'b1;
                    end
                end
                StOver: begin
                end
                default: begin
                    state_d = StRunning;
                end
            endcase
        end

        paused_d   = (state_d == StPaused);
        resuming_d = (state_d == StResuming);
        over_d     = (state_d == StOver);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRunning;
            tick_cnt_q  <= '0;
            sec_cnt_q   <= '0;
            countdown_q <= 4'd0;
            pause_q     <= 1'b1;
            game_tick_q <= 1'b0;
            paused_q    <= 1'b0;
            resuming_q  <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            sec_cnt_q   <= sec_cnt_d;
            countdown_q <= countdown_d;
            pause_q     <= pause_state;
            game_tick_q <= game_tick_d;
            paused_q    <= paused_d;
            resuming_q  <= resuming_d;
            over_q      <= over_d;
        end
    end

    assign game_tick = game_tick_q;
    assign paused    = paused_q;
    assign resuming  = resuming_q;
    assign over      = over_q;
    assign countdown = countdown_q;

endmodule
